instruction_fetch_unit: RTL and testbench

//   Fetch stage of the multi-cycle KGP-RISC core: owns the PC, reads the instruction memory
//   and holds the current instruction word. Drives opcode[5:0] straight into main_control.

---
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the multi-cycle KGP-RISC core: owns the PC, reads instruction memory and
// holds one instruction at a time for the downstream datapath.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [5:0]            opcode,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  instr_valid,
  output logic [1:0]            dbg_state_o
);

  // Handshake: instr/opcode/pc are valid while instr_valid is high; the instruction is
  // consumed on any clock edge where instr_valid is high and stall is low. No new read is
  // issued until the held instruction is consumed or a branch redirects the PC.

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic          rd_en_q;
  logic [CW-1:0] cnt_q;

  // rd_en_q is set on every transition into FETCH so the strobe lines up with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ~32'h3;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      rd_en_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      if (branch_taken && (state_q != IDLE)) begin
        // Redirect drops any in-flight read; instr_q keeps its old value.
        pc_q    <= branch_target & ~32'h3;
        valid_q <= 1'b0;
        state_q <= FETCH;
        rd_en_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
          end
          FETCH: begin
            cnt_q   <= CW'(MEM_LATENCY - 1);
            state_q <= WAIT;
          end
          WAIT: begin
            if (cnt_q == '0) begin
              instr_q <= imem_rdata;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          HOLD: begin
            if (!stall) begin
              pc_q    <= pc_q + 32'd4;
              valid_q <= 1'b0;
              state_q <= FETCH;
              rd_en_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign imem_rd_en  = rd_en_q;
  assign imem_addr   = pc_q[ADDR_WIDTH+1:2];
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: one instance at RESET_PC=0 for fetch, stall
// and redirect, and one at RESET_PC=FFFF_FFFC for PC wrap and mid-read reset.
module tb_instruction_fetch_unit;

  logic clk;
  logic [31:0] mem [0:1023];

  // Instance A: RESET_PC = 0
  logic        rst_a, stall_a, br_a;
  logic [31:0] tgt_a, rdata_a, instr_a, pc_a, pc4_a;
  logic        rd_en_a, valid_a;
  logic [9:0]  addr_a;
  logic [5:0]  opc_a;
  logic [1:0]  st_a;

  // Instance B: RESET_PC = FFFF_FFFC
  logic        rst_b, stall_b, br_b;
  logic [31:0] tgt_b, rdata_b, instr_b, pc_b, pc4_b;
  logic        rd_en_b, valid_b;
  logic [9:0]  addr_b;
  logic [5:0]  opc_b;
  logic [1:0]  st_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_WIDTH(10), .MEM_LATENCY(1), .RESET_PC(32'h0000_0000)) u_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .branch_taken(br_a), .branch_target(tgt_a),
    .imem_rd_en(rd_en_a), .imem_addr(addr_a), .imem_rdata(rdata_a), .instr(instr_a),
    .opcode(opc_a), .pc(pc_a), .pc_plus4(pc4_a), .instr_valid(valid_a), .dbg_state_o(st_a)
  );

  instruction_fetch_unit #(.ADDR_WIDTH(10), .MEM_LATENCY(1), .RESET_PC(32'hFFFF_FFFC)) u_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .branch_taken(br_b), .branch_target(tgt_b),
    .imem_rd_en(rd_en_b), .imem_addr(addr_b), .imem_rdata(rdata_b), .instr(instr_b),
    .opcode(opc_b), .pc(pc_b), .pc_plus4(pc4_b), .instr_valid(valid_b), .dbg_state_o(st_b)
  );

  // One-cycle-latency instruction memory models
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= mem[addr_a];
    if (rd_en_b) rdata_b <= mem[addr_b];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[0]    = 32'h0400_0000;
    mem[1]    = 32'h0800_0011;
    mem[2]    = 32'hF000_1234;
    mem[3]    = 32'hDEAD_BEEF;
    mem[64]   = 32'h1234_5678;
    mem[128]  = 32'hABCD_0001;
    mem[1023] = 32'h8C00_0FFF;
    rdata_a = 32'h0; rdata_b = 32'h0;
    rst_a = 1'b1; stall_a = 1'b0; br_a = 1'b0; tgt_a = 32'h0;
    rst_b = 1'b1; stall_b = 1'b0; br_b = 1'b0; tgt_b = 32'h0;

    // 1. Reset held for two edges, then first fetch
    tick(); tick();
    check("rst_valid", {31'b0, valid_a}, 32'd0);
    check("rst_rd_en", {31'b0, rd_en_a}, 32'd0);
    check("rst_pc", pc_a, 32'h0);
    check("rst_instr", instr_a, 32'h0);
    check("rst_state", {30'b0, st_a}, 32'd0);
    rst_a = 1'b0;
    tick();
    check("f0_rd_en", {31'b0, rd_en_a}, 32'd1);
    check("f0_addr", {22'b0, addr_a}, 32'd0);
    check("f0_valid", {31'b0, valid_a}, 32'd0);
    tick();
    check("w0_rd_en", {31'b0, rd_en_a}, 32'd0);
    check("w0_valid", {31'b0, valid_a}, 32'd0);
    tick();
    check("h0_valid", {31'b0, valid_a}, 32'd1);
    check("h0_opcode", {26'b0, opc_a}, 32'd1);
    check("h0_pc", pc_a, 32'h0);
    check("h0_pc4", pc4_a, 32'h4);

    // 2. Streaming with stall low
    tick();
    check("f1_valid", {31'b0, valid_a}, 32'd0);
    check("f1_rd_en", {31'b0, rd_en_a}, 32'd1);
    check("f1_addr", {22'b0, addr_a}, 32'd1);
    tick();
    tick();
    check("h1_valid", {31'b0, valid_a}, 32'd1);
    check("h1_opcode", {26'b0, opc_a}, 32'd2);
    check("h1_pc", pc_a, 32'h4);

    // 3. Stall for five cycles while pc=4 is held
    stall_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, valid_a}, 32'd1);
      check("stall_pc", pc_a, 32'h4);
      check("stall_instr", instr_a, 32'h0800_0011);
      check("stall_rd_en", {31'b0, rd_en_a}, 32'd0);
    end
    stall_a = 1'b0;
    tick();
    check("f2_rd_en", {31'b0, rd_en_a}, 32'd1);
    check("f2_pc", pc_a, 32'h8);
    check("f2_addr", {22'b0, addr_a}, 32'd2);
    tick();
    tick();
    check("h2_opcode", {26'b0, opc_a}, 32'h3C);
    check("h2_pc", pc_a, 32'h8);

    // 4a. Redirect during WAIT discards the read of pc=12
    tick();
    check("f3_pc", pc_a, 32'hC);
    tick();
    check("w3_state", {30'b0, st_a}, 32'd2);
    br_a = 1'b1; tgt_a = 32'h0000_0103;
    tick();
    br_a = 1'b0;
    check("br_rd_en", {31'b0, rd_en_a}, 32'd1);
    check("br_addr", {22'b0, addr_a}, 32'd64);
    check("br_pc", pc_a, 32'h100);
    check("br_valid", {31'b0, valid_a}, 32'd0);
    check("br_instr_kept", instr_a, 32'hF000_1234);
    tick();
    check("br_w_instr", instr_a, 32'hF000_1234);
    tick();
    check("br_h_valid", {31'b0, valid_a}, 32'd1);
    check("br_h_instr", instr_a, 32'h1234_5678);
    check("br_h_pc", pc_a, 32'h100);

    // 4b. Redirect with stall in the same HOLD cycle: branch wins
    stall_a = 1'b1; br_a = 1'b1; tgt_a = 32'h0000_0200;
    tick();
    br_a = 1'b0; stall_a = 1'b0;
    check("bs_rd_en", {31'b0, rd_en_a}, 32'd1);
    check("bs_addr", {22'b0, addr_a}, 32'd128);
    check("bs_pc", pc_a, 32'h200);
    check("bs_valid", {31'b0, valid_a}, 32'd0);
    tick();
    tick();
    check("bs_h_instr", instr_a, 32'hABCD_0001);
    check("bs_h_valid", {31'b0, valid_a}, 32'd1);

    // 5. PC wrap and reset mid-WAIT on instance B
    check("b_rst_pc", pc_b, 32'hFFFF_FFFC);
    check("b_rst_valid", {31'b0, valid_b}, 32'd0);
    rst_b = 1'b0;
    tick();
    check("b_f0_addr", {22'b0, addr_b}, 32'd1023);
    check("b_f0_rd_en", {31'b0, rd_en_b}, 32'd1);
    tick();
    tick();
    check("b_h0_instr", instr_b, 32'h8C00_0FFF);
    check("b_h0_pc4", pc4_b, 32'h0);
    tick();
    check("b_wrap_pc", pc_b, 32'h0);
    check("b_wrap_addr", {22'b0, addr_b}, 32'd0);
    check("b_wrap_rd_en", {31'b0, rd_en_b}, 32'd1);
    tick();
    check("b_wait_state", {30'b0, st_b}, 32'd2);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("b_rr_valid", {31'b0, valid_b}, 32'd0);
    check("b_rr_rd_en", {31'b0, rd_en_b}, 32'd0);
    check("b_rr_pc", pc_b, 32'hFFFF_FFFC);
    check("b_rr_instr", instr_b, 32'h0);
    tick();
    check("b_rf_addr", {22'b0, addr_b}, 32'd1023);
    check("b_rf_rd_en", {31'b0, rd_en_b}, 32'd1);
    tick();
    tick();
    check("b_rh_valid", {31'b0, valid_b}, 32'd1);
    check("b_rh_instr", instr_b, 32'h8C00_0FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
